// File: rtl/cep_scratchpad_bd_pkg.sv
// Shared types and constants for the scratchpad backdoor port.
package cep_scratchpad_bd_pkg;

    localparam int unsigned BD_WORD_BYTES = 8;
    localparam int unsigned BD_ADDR_WIDTH = 32;
    localparam int unsigned BD_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StRdata,
        StRsp
    } bd_state_e;

    typedef struct packed {
        logic                     we;
        logic [BD_ADDR_WIDTH-1:0] addr;
        logic [BD_DATA_WIDTH-1:0] wdata;
    } bd_req_t;

    // Starvation counter width; at least one bit so a limit of 0 still elaborates.
    function automatic int unsigned starve_cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/scratchpad_bd_arb.sv
// Functional-vs-backdoor grant select with a saturating starvation counter.
module scratchpad_bd_arb
    import cep_scratchpad_bd_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bd_pending_i,
    input  logic fn_req_i,
    output logic bd_issue_o,
    output logic fn_gnt_o
);

    localparam int unsigned CntW = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

    assign bd_issue_o = bd_pending_i & (~fn_req_i | (starve_cnt_q >= Limit));
    assign fn_gnt_o   = fn_req_i & ~bd_issue_o;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (bd_issue_o) begin
            starve_cnt_d = '0;
        end else if (bd_pending_i && fn_req_i && (starve_cnt_q < Limit)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/scratchpad_backdoor_port.sv
// Backdoor valid/ready responder sharing the scratchpad SRAM with the functional port.
// Optional address range check enabled by SCRATCHPAD_BD_RANGE_CHECK_EN.
module scratchpad_backdoor_port
    import cep_scratchpad_bd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned MEM_DEPTH    = 65536,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fn_req_i,
    input  logic                         fn_we_i,
    input  logic [ADDR_WIDTH-1:0]        fn_addr_i,
    input  logic [DATA_WIDTH-1:0]        fn_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      fn_mask_i,
    output logic                         fn_gnt_o,
    output logic                         fn_rvalid_o,
    output logic [DATA_WIDTH-1:0]        fn_rdata_o,
    input  logic                         bd_req_valid_i,
    output logic                         bd_req_ready_o,
    input  logic                         bd_we_i,
    input  logic [ADDR_WIDTH-1:0]        bd_addr_i,
    input  logic [DATA_WIDTH-1:0]        bd_wdata_i,
    output logic                         bd_rsp_valid_o,
    input  logic                         bd_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]        bd_rdata_o,
    output logic                         bd_rsp_err_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]      mem_mask_o,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

    localparam int unsigned IdxW     = $clog2(MEM_DEPTH);
    localparam int unsigned ByteOffW = $clog2(BD_WORD_BYTES);

    bd_state_e             state_q, state_d;
    bd_req_t               req_q, req_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  fn_rvalid_q;

    logic bd_accept;
    logic bd_oor;
    logic bd_pending;
    logic bd_issue;
    logic fn_gnt;
    logic unused_addr;

    assign bd_accept  = bd_req_valid_i & bd_req_ready_o;
    assign bd_pending = rst_n & (state_q == StArb);

`ifdef SCRATCHPAD_BD_RANGE_CHECK_EN
    logic [ADDR_WIDTH-1:0] bd_word_full;
    assign bd_word_full = ADDR_WIDTH'(bd_addr_i >> ByteOffW);
    assign bd_oor       = (bd_word_full >= ADDR_WIDTH'(MEM_DEPTH));
`else
    // Index wraps by truncation; MEM_DEPTH is expected to be a power of two.
    assign bd_oor = 1'b0;
`endif

    scratchpad_bd_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .bd_pending_i (bd_pending),
        .fn_req_i     (fn_req_i),
        .bd_issue_o   (bd_issue),
        .fn_gnt_o     (fn_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            fn_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            fn_rvalid_q <= fn_gnt_o & ~fn_we_i;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bd_accept) begin
                    req_d.we    = bd_we_i;
                    req_d.addr  = BD_ADDR_WIDTH'(bd_addr_i);
                    req_d.wdata = BD_DATA_WIDTH'(bd_wdata_i);
                    rdata_d     = '0;
                    err_d       = bd_oor;
                    state_d     = bd_oor ? StRsp : StArb;
                end
            end
            StArb: begin
                if (bd_issue) begin
                    state_d = req_q.we ? StRsp : StRdata;
                end
            end
            StRdata: begin
                rdata_d = mem_rdata_i;
                state_d = StRsp;
            end
            StRsp: begin
                if (bd_rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bd_req_ready_o = rst_n & (state_q == StIdle);
        bd_rsp_valid_o = (state_q == StRsp);
        bd_rdata_o     = rdata_q;
        bd_rsp_err_o   = err_q;
        fn_gnt_o       = rst_n & fn_gnt;
        fn_rvalid_o    = fn_rvalid_q;
        fn_rdata_o     = mem_rdata_i;
        if (bd_issue) begin
            mem_req_o   = 1'b1;
            mem_we_o    = req_q.we;
            mem_addr_o  = req_q.addr[ByteOffW +: IdxW];
            mem_wdata_o = DATA_WIDTH'(req_q.wdata);
            mem_mask_o  = '1;
        end else begin
            mem_req_o   = fn_gnt_o;
            mem_we_o    = fn_we_i;
            mem_addr_o  = fn_addr_i[ByteOffW +: IdxW];
            mem_wdata_o = fn_wdata_i;
            mem_mask_o  = fn_mask_i;
        end
    end

    // Byte-offset and wrapped high address bits are intentionally ignored.
    assign unused_addr = ^{fn_addr_i, req_q.addr};

endmodule

// File: tb/tb_scratchpad_backdoor_port.sv
// Scoreboard bench for scratchpad_backdoor_port with a 1024-word SRAM model.
module tb_scratchpad_backdoor_port;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 1024;
    localparam logic [63:0] WORD0 = 64'h0123_4567_89AB_CDEF;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          fn_req_i, fn_we_i;
    logic [AW-1:0] fn_addr_i;
    logic [DW-1:0] fn_wdata_i;
    logic [7:0]    fn_mask_i;
    logic          fn_gnt_o, fn_rvalid_o;
    logic [DW-1:0] fn_rdata_o;
    logic          bd_req_valid_i, bd_req_ready_o, bd_we_i;
    logic [AW-1:0] bd_addr_i;
    logic [DW-1:0] bd_wdata_i;
    logic          bd_rsp_valid_o, bd_rsp_ready_i, bd_rsp_err_o;
    logic [DW-1:0] bd_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [9:0]    mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [7:0]    mem_mask_o;
    logic [DW-1:0] mem_rdata_i;

    logic [63:0] sram [DEPTH];
    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;

    // Results captured by bd_op for the caller's extra checks.
    logic        rv_issue, rv_after;
    logic [63:0] rd_issue;

    scratchpad_backdoor_port #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_DEPTH    (DEPTH),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fn_req_i       (fn_req_i),
        .fn_we_i        (fn_we_i),
        .fn_addr_i      (fn_addr_i),
        .fn_wdata_i     (fn_wdata_i),
        .fn_mask_i      (fn_mask_i),
        .fn_gnt_o       (fn_gnt_o),
        .fn_rvalid_o    (fn_rvalid_o),
        .fn_rdata_o     (fn_rdata_o),
        .bd_req_valid_i (bd_req_valid_i),
        .bd_req_ready_o (bd_req_ready_o),
        .bd_we_i        (bd_we_i),
        .bd_addr_i      (bd_addr_i),
        .bd_wdata_i     (bd_wdata_i),
        .bd_rsp_valid_o (bd_rsp_valid_o),
        .bd_rsp_ready_i (bd_rsp_ready_i),
        .bd_rdata_o     (bd_rdata_o),
        .bd_rsp_err_o   (bd_rsp_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_mask_o     (mem_mask_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read, byte-masked write.
    always @(posedge clk) begin
        if (!rst_n) begin
            sram[0] <= WORD0;
        end else if (mem_req_o) begin
            mem_rdata_i <= sram[mem_addr_o];
            if (mem_we_o) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_mask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response handshake is presented.
    always @(negedge clk) begin
        if (rst_n && bd_rsp_valid_o && bd_rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(bd_rsp_valid_o), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", bd_rdata_o, e.rdata);
                check("rsp_err", 64'(bd_rsp_err_o), 64'(e.err));
            end
        end
    end

    task automatic bd_op(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_err, input int exp_issue,
                         input int exp_rsp, input int exp_nfn, input logic [9:0] exp_idx);
        int   issue_lat, rsp_lat, nfn;
        logic accepted;
        logic [9:0] iss_addr;
        logic [7:0] iss_mask;
        logic iss_we;
        issue_lat = 0; rsp_lat = 0; nfn = 0; accepted = 1'b0;
        iss_addr = '0; iss_mask = '0; iss_we = 1'b0;
        rv_issue = 1'b0; rv_after = 1'b1; rd_issue = '0;
        @(posedge clk); #1;
        bd_req_valid_i = 1'b1; bd_we_i = we; bd_addr_i = addr; bd_wdata_i = wdata;
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge clk);
            accepted = bd_req_ready_o;
        end
        check("bd_accept", 64'(accepted), 64'd1);
        @(posedge clk); #1;
        bd_req_valid_i = 1'b0;
        if (accepted) begin
            exp_q.push_back('{rdata: exp_rdata, err: exp_err});
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (issue_lat == 0 && mem_req_o && !fn_gnt_o) begin
                    issue_lat = k; iss_addr = mem_addr_o; iss_mask = mem_mask_o; iss_we = mem_we_o;
                    rv_issue = fn_rvalid_o; rd_issue = fn_rdata_o;
                end else if (issue_lat == 0 && fn_gnt_o) begin
                    nfn++;
                end
                if (issue_lat != 0 && k == issue_lat + 1) rv_after = fn_rvalid_o;
                if (bd_rsp_valid_o) begin
                    rsp_lat = k;
                    break;
                end
            end
        end
        check("issue_lat", 64'(issue_lat), 64'(exp_issue));
        check("rsp_lat", 64'(rsp_lat), 64'(exp_rsp));
        check("fn_grants_before_issue", 64'(nfn), 64'(exp_nfn));
        if (exp_issue != 0) begin
            check("issue_idx", 64'(iss_addr), 64'(exp_idx));
            check("issue_mask", 64'(iss_mask), 64'hFF);
            check("issue_we", 64'(iss_we), 64'(we));
        end
    endtask

    task automatic fn_access(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                             input logic [7:0] mask, input logic [63:0] exp_rdata);
        @(posedge clk); #1;
        fn_req_i = 1'b1; fn_we_i = we; fn_addr_i = addr; fn_wdata_i = wdata; fn_mask_i = mask;
        @(negedge clk);
        check("fn_gnt", 64'(fn_gnt_o), 64'd1);
        @(posedge clk); #1;
        fn_req_i = 1'b0; fn_we_i = 1'b0;
        @(negedge clk);
        check("fn_rvalid", 64'(fn_rvalid_o), 64'(!we));
        if (!we) check("fn_rdata", fn_rdata_o, exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        fn_req_i = 1'b1; fn_we_i = 1'b0; fn_addr_i = '0; fn_wdata_i = '0; fn_mask_i = '0;
        bd_req_valid_i = 1'b0; bd_we_i = 1'b0; bd_addr_i = '0; bd_wdata_i = '0;
        bd_rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_low", 64'(bd_req_ready_o), 64'd0);
        check("rst_mem_req_low", 64'(mem_req_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; fn_req_i = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(bd_req_ready_o), 64'd1);
        check("reset_rsp_valid", 64'(bd_rsp_valid_o), 64'd0);
        check("reset_rdata", bd_rdata_o, 64'd0);
        check("reset_err", 64'(bd_rsp_err_o), 64'd0);
        check("reset_fn_rvalid", 64'(fn_rvalid_o), 64'd0);

        // Uncontended write then read; latencies 2 and 3.
        bd_op(1'b1, 32'h1000, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0, 1, 2, 0, 10'd512);
        bd_op(1'b0, 32'h1000, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1, 3, 0, 10'd512);

        // Functional path: read back, then a low-half masked write.
        fn_access(1'b0, 32'h1000, 64'd0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D);
        fn_access(1'b1, 32'h1000, 64'h0000_0000_1234_5678, 8'h0F, 64'd0);

        // Continuous functional reads of 0x2000 (wraps to word 0) starve the backdoor read.
        @(posedge clk); #1;
        fn_req_i = 1'b1; fn_we_i = 1'b0; fn_addr_i = 32'h2000;
        bd_op(1'b0, 32'h1000, 64'd0, 64'hDEAD_BEEF_1234_5678, 1'b0, 5, 7, 4, 10'd512);
        check("fn_rvalid_at_issue", 64'(rv_issue), 64'd1);
        check("fn_rdata_at_issue", rd_issue, WORD0);
        check("fn_rvalid_after_bd_read", 64'(rv_after), 64'd0);
        @(posedge clk); #1;
        fn_req_i = 1'b0;

        // Response back-pressure: outputs hold and no new request is accepted.
        @(posedge clk); #1;
        bd_rsp_ready_i = 1'b0;
        bd_op(1'b0, 32'h1000, 64'd0, 64'hDEAD_BEEF_1234_5678, 1'b0, 1, 3, 0, 10'd512);
        bd_req_valid_i = 1'b1; bd_we_i = 1'b1; bd_addr_i = 32'h1000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bd_rsp_valid_o), 64'd1);
            check("hold_rdata", bd_rdata_o, 64'hDEAD_BEEF_1234_5678);
            check("hold_ready", 64'(bd_req_ready_o), 64'd0);
        end
        @(posedge clk); #1;
        bd_req_valid_i = 1'b0; bd_rsp_ready_i = 1'b1;
        @(negedge clk);

        // Reset while in RDATA drops the read with no response.
        @(posedge clk); #1;
        bd_req_valid_i = 1'b1; bd_we_i = 1'b0; bd_addr_i = 32'h1000;
        @(negedge clk);
        check("t5_ready", 64'(bd_req_ready_o), 64'd1);
        @(posedge clk); #1;
        bd_req_valid_i = 1'b0;
        @(negedge clk);
        check("t5_issue", 64'(mem_req_o), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; fn_req_i = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", 64'(bd_req_ready_o), 64'd0);
        check("t5_rst_mem_req", 64'(mem_req_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; fn_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_rsp", 64'(bd_rsp_valid_o), 64'd0);
            check("t5_ready_after", 64'(bd_req_ready_o), 64'd1);
        end

        // Out-of-range backdoor read (word 1024 of a 1024-word array).
`ifdef SCRATCHPAD_BD_RANGE_CHECK_EN
        bd_op(1'b0, 32'h2000, 64'd0, 64'd0, 1'b1, 0, 1, 0, 10'd0);
`else
        bd_op(1'b0, 32'h2000, 64'd0, WORD0, 1'b0, 1, 3, 0, 10'd0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
